isp_yuv422_pack: RTL
====================

# isp_yuv422_pack

Downstream neighbour of the ISP pipeline output. Takes the per-pixel YUV444 stream (href/vsync qualified, one pixel per pclk) and converts it to YUYV 4:2:2 by averaging chroma over horizontal pixel pairs. It packs two pixels per 32-bit word and buffers the words in a small FIFO. The FIFO drains through a valid/ready handshake toward the frame-buffer writer, with frame/line markers and overflow/line-error status for firmware.

## Interface
Parameters:
- BITS, 8, component width; word is 4*BITS
- WIDTH, 1280, active pixels per line; must be even
- HEIGHT, 960, active lines per frame
- FIFO_DEPTH, 16, word FIFO depth; power of 2, ≥4

Ports:
- pclk  in  1  pixel clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- in_href  in  1  pixel valid / line active
- in_vsync  in  1  high = frame blanking; rising edge = frame boundary
- in_y, in_u, in_v  in  BITS each  YUV444 pixel
- out_valid  out  1  FIFO head word valid
- out_ready  in  1  consumer accepts head word
- out_data  out  4*BITS  {V, Y1, U, Y0}; Y0 is the earlier pixel
- out_sof  out  1  head word is the first word of a frame
- out_eol  out  1  head word is the last word of a line
- frame_done  out  1  one-cycle pulse when the last word of line HEIGHT is pushed
- ovf  out  1  sticky; FIFO overflowed this frame
- line_err  out  1  sticky; a line was odd-length, short, or long this frame

## Operation
- Frame start: an in_vsync rising edge (registered compare) does the following:
  - clears the pixel phase, word index and line counter;
  - clears ovf and line_err;
  - exits drop mode and arms sof.
  - FIFO contents are not flushed.
- Pixel pairing: the phase bit toggles on each href-high cycle and is reset to 0 on every href rising edge.
  - Phase 0: latch Y0, U0, V0.
  - Phase 1: form the word Y0, Y1, U=(U0+U1+1)>>1, V=(V0+V1+1)>>1. The sum uses a BITS+1 width, so it never overflows.
- Word index: counts 0..WIDTH/2-1 within a line.
  - The word at index WIDTH/2-1 carries eol=1.
  - The first word pushed after sof is armed carries sof=1; sof is then disarmed.
- Line end (href falling edge):
  - Odd phase pending: discard the lone pixel and set line_err.
  - Index short of WIDTH/2 (no eol issued): set line_err.
  - In both cases, increment the line counter.
- Pixels beyond WIDTH in a line are discarded and set line_err.
- Lines beyond HEIGHT are still packed. frame_done fires only once per frame, on the eol push of line index HEIGHT-1.
- FIFO stores {sof, eol, data}. It is show-ahead: out_data/out_sof/out_eol are valid whenever out_valid=1.
  - A push succeeds if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
- Overflow handling:
  - A push that does not succeed sets ovf and enters drop mode.
  - In drop mode, all further words of the frame are discarded until the next vsync rising edge.
  - frame_done is suppressed in drop mode.
- The pop side is independent of the input state and continues draining during drop mode and blanking.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof=0, out_eol=0, frame_done=0, ovf=0, line_err=0. FIFO is empty, phase=0, counters=0, sof armed.
- Input registered on cycle t. For the phase-1 pixel at cycle t, the FIFO write occurs at t+1.
- If the FIFO was empty, out_valid=1 from t+2. Latency is 2 cycles from the second pixel to the head.
- Throughput: 1 word per 2 pclk in; 1 word per pclk out when out_ready=1.
- Pop occurs on the cycle where out_valid & out_ready. The next head is presented on the following cycle.
- out_data is held stable while out_valid=1 and out_ready=0.
- frame_done is asserted on the cycle after the final eol word is written.
- ovf and line_err assert the cycle after the causing event and clear the cycle after the vsync rising edge.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). The first frame after reset starts at the next vsync rising edge; pixels before it are packed with sof armed.

## Test plan
- Frame of 4×2 pixels (WIDTH=4, HEIGHT=2), Y=0..7, U=10,12,…, V=20,22,…, out_ready=1 → 4 words:
  - 1st word {21,1,11,0} with sof=1;
  - words 2 and 4 have eol=1;
  - frame_done pulses once;
  - ovf=0, line_err=0.
- Chroma rounding: U pair 0,1 → 1; U pair 255,255 → 255; V pair 254,255 → 255.
- out_ready=0 through a full 1280×960 frame with FIFO_DEPTH=16:
  - 16 words held, ovf=1 at the 17th push;
  - no more pushes that frame, no frame_done.
  - Next vsync rise clears ovf. After draining, the next frame's first word has sof=1.
- Backpressure pattern out_ready toggling 1/0 each cycle → all WIDTH/2×HEIGHT words delivered in order, ovf=0.
- Line of 5 pixels (WIDTH=4) → 2 words (eol on 2nd), 5th pixel discarded, line_err=1. A 3-pixel line → 1 word, no eol, line_err=1.
- rst pulse mid-line → outputs zero immediately. Subsequent frame packs correctly with sof on its first word.

Source files
------------

// File: rtl/isp_yuv422_pack.sv
// isp_yuv422_pack
// Converts a per-pixel YUV444 stream (href/vsync qualified) into YUYV 4:2:2
// words. Chroma is averaged with rounding over each horizontal pixel pair. The
// words are buffered in a show-ahead FIFO that drains through valid/ready.
//
// Ports
//   pclk, rst             : pixel clock, asynchronous active-high reset
//   in_href, in_vsync     : line active / frame blanking (rise = frame start)
//   in_y, in_u, in_v      : YUV444 pixel, BITS each
//   out_valid, out_ready  : FIFO head handshake
//   out_data              : {V, Y1, U, Y0}, Y0 is the earlier pixel
//   out_sof, out_eol      : head word is first of frame / last of line
//   frame_done            : pulse after the eol word of line HEIGHT-1 is written
//   ovf, line_err         : sticky per-frame status, cleared by vsync rise
module isp_yuv422_pack #(
    parameter int BITS       = 8,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 960,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              in_href,
    input  logic              in_vsync,
    input  logic [BITS-1:0]   in_y,
    input  logic [BITS-1:0]   in_u,
    input  logic [BITS-1:0]   in_v,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*BITS-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              frame_done,
    output logic              ovf,
    output logic              line_err
);

    localparam int HALF = WIDTH / 2;
    localparam int WIW  = $clog2(HALF + 1);
    localparam int LCW  = $clog2(HEIGHT + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = 4 * BITS + 2;

    localparam logic [WIW-1:0] IDX_FULL  = WIW'(HALF);
    localparam logic [WIW-1:0] IDX_LAST  = WIW'(HALF - 1);
    localparam logic [LCW-1:0] LINE_LAST = LCW'(HEIGHT - 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

    // input register stage
    logic            href_r, href_p, vsync_r, vsync_p;
    logic [BITS-1:0] y_r, u_r, v_r;

    // packing state
    logic            phase;
    logic [WIW-1:0]  widx;
    logic [LCW-1:0]  line_cnt;
    logic [BITS-1:0] y0, u0, v0;
    logic            sof_armed, drop, done_seen;

    // FIFO
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head;

    // combinational
    logic            href_rise, href_fall, vsync_rise;
    logic            phase_eff, line_full, form, eol;
    logic [WIW-1:0]  widx_eff;
    logic [BITS-1:0] u_avg, v_avg;
    logic            pop, try_push, push_ok, push_fail, last_push;
    logic [EW-1:0]   wr_entry;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            href_r  <= 1'b0;
            href_p  <= 1'b0;
            vsync_r <= 1'b0;
            vsync_p <= 1'b0;
            y_r     <= '0;
            u_r     <= '0;
            v_r     <= '0;
        end else begin
            href_r  <= in_href;
            href_p  <= href_r;
            vsync_r <= in_vsync;
            vsync_p <= vsync_r;
            y_r     <= in_y;
            u_r     <= in_u;
            v_r     <= in_v;
        end
    end

    always_comb begin
        href_rise  = href_r & ~href_p;
        href_fall  = ~href_r & href_p;
        vsync_rise = vsync_r & ~vsync_p;
        // a new line restarts pairing and indexing on its very first pixel
        phase_eff  = href_rise ? 1'b0 : phase;
        widx_eff   = href_rise ? '0 : widx;
        line_full  = (widx_eff == IDX_FULL);
        form       = href_r & ~line_full & ~vsync_rise & phase_eff;
        eol        = (widx_eff == IDX_LAST);
        // BITS+1 wide sum, rounded half up
        u_avg      = BITS'(({1'b0, u0} + {1'b0, u_r} + 1'b1) >> 1);
        v_avg      = BITS'(({1'b0, v0} + {1'b0, v_r} + 1'b1) >> 1);
        wr_entry   = {sof_armed, eol, v_avg, y_r, u_avg, y0};
        pop        = out_valid & out_ready;
        try_push   = form & ~drop;
        push_ok    = try_push & ((count < DEPTH_C) | pop);
        push_fail  = try_push & ~push_ok;
        last_push  = push_ok & eol & (line_cnt == LINE_LAST) & ~done_seen;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phase      <= 1'b0;
            widx       <= '0;
            line_cnt   <= '0;
            y0         <= '0;
            u0         <= '0;
            v0         <= '0;
            sof_armed  <= 1'b1;
            drop       <= 1'b0;
            done_seen  <= 1'b0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
            line_err   <= 1'b0;
        end else if (vsync_rise) begin
            phase      <= 1'b0;
            widx       <= '0;
            line_cnt   <= '0;
            sof_armed  <= 1'b1;
            drop       <= 1'b0;
            done_seen  <= 1'b0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            frame_done <= last_push;
            if (last_push)
                done_seen <= 1'b1;
            if (href_r) begin
                if (line_full) begin
                    // pixels past WIDTH are dropped without toggling the phase
                    line_err <= 1'b1;
                end else if (!phase_eff) begin
                    y0    <= y_r;
                    u0    <= u_r;
                    v0    <= v_r;
                    phase <= 1'b1;
                    widx  <= widx_eff;
                end else begin
                    phase <= 1'b0;
                    widx  <= widx_eff + 1'b1;
                end
            end
            if (href_fall) begin
                if (phase || (widx != IDX_FULL))
                    line_err <= 1'b1;
                if (line_cnt != '1)
                    line_cnt <= line_cnt + 1'b1;
            end
            if (push_ok)
                sof_armed <= 1'b0;
            if (push_fail) begin
                ovf  <= 1'b1;
                drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (push_ok)
            mem[wptr] <= wr_entry;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // head is gated so the outputs read zero while the FIFO is empty
    always_comb begin
        out_valid = (count != '0);
        head      = out_valid ? mem[rptr] : '0;
        out_sof   = head[EW-1];
        out_eol   = head[EW-2];
        out_data  = head[4*BITS-1:0];
    end

endmodule
